// File: rtl/fsm1011_pkg.sv
// Shared definitions for the fsm1011 detector and its serializer front end:
// serializer state encoding, default geometry and the detector's target pattern.
package fsm1011_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_BIT_DIV = 1;

  localparam logic [3:0] SEQ_1011 = 4'b1011;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..BIT_DIV-1 while enabled and flags the final count.
// With BIT_DIV=1 the counter stays at 0 and tick follows en.
module bit_tick_gen #(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic at_zero
);

  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick    = en && (r_cnt == LAST);
  assign at_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the fsm1011 detector: words arrive on a
// valid/ready handshake and leave on x one bit at a time, gap-free when streamed.
module seq_bit_serializer
  import fsm1011_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BIT_DIV   = DEF_BIT_DIV,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             bit_strobe,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;

  logic             w_shifting;
  logic             w_tick;
  logic             w_div_zero;
  logic             w_last;
  logic             w_ready;
  logic             w_load;
  logic             w_head;
  logic [WIDTH-1:0] w_shifted;

  assign w_shifting = (r_state == SHIFT);
  assign w_last     = w_tick && (r_bitcnt == LAST_BIT);
  // Ready depends only on state and counters so upstream can never loop valid into it.
  assign w_ready    = (r_state == IDLE) || w_last;
  assign w_load     = din_valid && w_ready;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_head    = r_shreg[WIDTH-1];
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign w_head    = r_shreg[0];
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  bit_tick_gen #(
    .BIT_DIV (BIT_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_load),
    .en      (w_shifting),
    .tick    (w_tick),
    .at_zero (w_div_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else if (w_load) begin
      r_state  <= SHIFT;
      r_shreg  <= din;
      r_bitcnt <= '0;
    end else if (w_last) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
    end else if (w_tick) begin
      r_shreg  <= w_shifted;
      r_bitcnt <= r_bitcnt + BW'(1);
    end
  end

  // x comes straight from registers, so din never reaches it combinationally.
  assign x          = w_shifting && w_head;
  assign x_valid    = w_shifting;
  assign busy       = w_shifting;
  assign bit_strobe = w_shifting && w_div_zero;
  assign din_ready  = w_ready;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench: three serializer configurations (8/1/MSB, 8/50/MSB, 8/1/LSB)
// driven in one linear sequence with hand-computed expected bit streams.
module tb_seq_bit_serializer;
  import fsm1011_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_din = '0, b_din = '0, c_din = '0;
  logic a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
  logic a_ready, a_x, a_xv, a_strobe, a_busy;
  logic b_ready, b_x, b_xv, b_strobe, b_busy;
  logic c_ready, c_x, c_xv, c_strobe, c_busy;

  int checks = 0;
  int failures = 0;

  seq_bit_serializer #(.WIDTH(8), .BIT_DIV(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
    .x(a_x), .x_valid(a_xv), .bit_strobe(a_strobe), .busy(a_busy)
  );

  seq_bit_serializer #(.WIDTH(8), .BIT_DIV(50), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
    .x(b_x), .x_valid(b_xv), .bit_strobe(b_strobe), .busy(b_busy)
  );

  seq_bit_serializer #(.WIDTH(8), .BIT_DIV(1), .MSB_FIRST(0)) dut_c (
    .clk(clk), .rst(rst), .din(c_din), .din_valid(c_valid), .din_ready(c_ready),
    .x(c_x), .x_valid(c_xv), .bit_strobe(c_strobe), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present a word to dut_a on one edge, drop valid, and return in the first bit clock.
  task automatic handshake_a(input logic [7:0] word);
    @(negedge clk);
    a_din = word;
    a_valid = 1'b1;
    chk("a_ready_before_load", a_ready, 1'b1);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  // seq[7] is the first bit expected on x.
  task automatic expect_a(input string tag, input logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_x"}, a_x, seq[7-i]);
      chk({tag, "_xvalid"}, a_xv, 1'b1);
      chk({tag, "_ready"}, a_ready, (i == 7));
      chk({tag, "_strobe"}, a_strobe, 1'b1);
    end
    @(negedge clk);
    chk({tag, "_xvalid_after"}, a_xv, 1'b0);
    chk({tag, "_x_after"}, a_x, 1'b0);
  endtask

  initial begin
    logic [15:0] stream;
    logic [3:0]  hist;
    int          hits;
    int          strobes;
    logic [7:0]  exp_b;

    // Reset state
    #12;
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_x", a_x, 1'b0);
    chk("rst_xvalid", a_xv, 1'b0);
    chk("rst_strobe", a_strobe, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", a_ready, 1'b1);
    chk("idle_busy", a_busy, 1'b0);

    // Single word 0xB6, MSB first
    handshake_a(8'hB6);
    expect_a("b6", 8'b1011_0110);
    $display("txn single 0xB6 done");

    // Back-to-back 0x0B then 0xB0 with valid held high
    stream = 16'b0000_1011_1011_0000;
    hist = '0;
    hits = 0;
    @(negedge clk);
    a_din = 8'h0B;
    a_valid = 1'b1;
    @(negedge clk);
    a_din = 8'hB0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk("b2b_x", a_x, stream[15-i]);
      chk("b2b_xvalid", a_xv, 1'b1);
      if (i == 7) chk("b2b_ready_boundary", a_ready, 1'b1);
      if (i == 8) a_valid = 1'b0;
      hist = {hist[2:0], a_x};
      if (i >= 3 && hist == SEQ_1011) hits++;
    end
    chk_int("b2b_1011_hits", hits, 2);
    @(negedge clk);
    chk("b2b_xvalid_after", a_xv, 1'b0);
    $display("txn stream 0x0B,0xB0 done hits=%0d", hits);

    // valid pulsed mid-word must not load a new word
    handshake_a(8'hC5);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("pulse_x", a_x, (i == 0 || i == 1 || i == 5 || i == 7));
      chk("pulse_ready", a_ready, (i == 7));
      if (i == 2) begin
        a_din = 8'h3C;
        a_valid = 1'b1;
      end
      if (i == 3) a_valid = 1'b0;
    end
    @(negedge clk);
    chk("pulse_idle_after", a_xv, 1'b0);
    $display("txn 0xC5 with ignored pulse done");

    // Reset asserted during bit 3 of 0xFF
    handshake_a(8'hFF);
    repeat (3) @(negedge clk);
    chk("mid_x_before_rst", a_x, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_x", a_x, 1'b0);
    chk("mid_rst_xvalid", a_xv, 1'b0);
    chk("mid_rst_ready", a_ready, 1'b1);
    chk("mid_rst_busy", a_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    handshake_a(8'h81);
    expect_a("post_rst_81", 8'b1000_0001);
    $display("txn reset mid-word then 0x81 done");

    // BIT_DIV=50, word 0x5A
    exp_b = 8'b0101_1010;
    strobes = 0;
    @(negedge clk);
    b_din = 8'h5A;
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      chk("div50_x", b_x, exp_b[7 - c / 50]);
      chk("div50_xvalid", b_xv, 1'b1);
      chk("div50_strobe", b_strobe, (c % 50 == 0));
      chk("div50_ready", b_ready, (c == 399));
      if (b_strobe) strobes++;
    end
    chk_int("div50_strobe_count", strobes, 8);
    @(negedge clk);
    chk("div50_xvalid_after", b_xv, 1'b0);
    $display("txn div50 0x5A done strobes=%0d", strobes);

    // LSB first, word 0x0D
    @(negedge clk);
    c_din = 8'h0D;
    c_valid = 1'b1;
    @(negedge clk);
    c_valid = 1'b0;
    stream = 16'b1011_0000_0000_0000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("lsb_x", c_x, stream[15-i]);
      chk("lsb_xvalid", c_xv, 1'b1);
    end
    @(negedge clk);
    chk("lsb_xvalid_after", c_xv, 1'b0);
    $display("txn lsb-first 0x0D done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
